// File: rtl/mem_block_mover_if.sv
// Bus bundle for the block mover: host control fields plus the memory data port.
// The master modport is the mover itself; the slave modport is its environment
// (host that issues requests, memory that answers reads, arbiter that grants).
interface mem_block_mover_if #(
  parameter int WORD_SIZE = 8,
  parameter int LEN_WIDTH = WORD_SIZE + 1
);
  logic                 start;
  logic                 mode;
  logic [WORD_SIZE-1:0] src;
  logic [WORD_SIZE-1:0] dst;
  logic [LEN_WIDTH-1:0] len;
  logic [WORD_SIZE-1:0] fill_value;
  logic                 grant;
  logic [1:0]           op;
  logic [WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] write_data;
  logic [WORD_SIZE-1:0] read_data;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, mode, src, dst, len, fill_value, grant, read_data,
    output op, addr, write_data, busy, done
  );

  modport slave (
    output start, mode, src, dst, len, fill_value, grant, read_data,
    input  op, addr, write_data, busy, done
  );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / fill engine on the data-memory port. Copies len words from src
// to dst (descending when the destination overlaps the tail of the source) or
// fills len words at dst with a constant. One memory access per granted cycle.
module mem_block_mover #(
  parameter int WORD_SIZE = 8,
  parameter int LEN_WIDTH = WORD_SIZE + 1
) (
  input logic              clk,
  input logic              reset,
  mem_block_mover_if.master bus
);
  localparam logic [1:0] MEM_NOP   = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t               state, state_next;
  logic                 mode_reg, mode_next;
  logic                 desc_reg, desc_next;
  logic [WORD_SIZE-1:0] src_ptr, src_ptr_next;
  logic [WORD_SIZE-1:0] dst_ptr, dst_ptr_next;
  logic [WORD_SIZE-1:0] data_reg, data_next;
  logic [WORD_SIZE-1:0] fill_reg, fill_next;
  logic [LEN_WIDTH-1:0] count, count_next;

  logic [LEN_WIDTH-1:0] src_wide, dst_wide, src_end;
  logic                 overlap;
  logic [WORD_SIZE-1:0] len_word;
  logic [WORD_SIZE-1:0] step;

  // Overlap test in the wide domain so src+len never wraps back below dst.
  always_comb begin
    src_wide = LEN_WIDTH'(bus.src);
    dst_wide = LEN_WIDTH'(bus.dst);
    src_end  = src_wide + bus.len;
    overlap  = (dst_wide > src_wide) && (dst_wide < src_end);
    len_word = WORD_SIZE'(bus.len);
    step     = desc_reg ? {WORD_SIZE{1'b1}} : WORD_SIZE'(1);
  end

  // Next-state and datapath update; every register holds unless a branch moves it.
  always_comb begin
    state_next   = state;
    mode_next    = mode_reg;
    desc_next    = desc_reg;
    src_ptr_next = src_ptr;
    dst_ptr_next = dst_ptr;
    data_next    = data_reg;
    fill_next    = fill_reg;
    count_next   = count;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_next  = bus.mode;
          fill_next  = bus.fill_value;
          count_next = bus.len;
          desc_next  = ~bus.mode & overlap;
          if (~bus.mode & overlap) begin
            src_ptr_next = bus.src + len_word - WORD_SIZE'(1);
            dst_ptr_next = bus.dst + len_word - WORD_SIZE'(1);
          end else begin
            src_ptr_next = bus.src;
            dst_ptr_next = bus.dst;
          end
          if (bus.len == LEN_WIDTH'(0)) begin
            state_next = DONE;
          end else if (bus.mode) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        if (bus.grant) begin
          data_next  = bus.read_data;
          state_next = WR;
        end else begin
          state_next = RD;
        end
      end
      WR: begin
        if (bus.grant) begin
          src_ptr_next = src_ptr + step;
          dst_ptr_next = dst_ptr + step;
          count_next   = count - LEN_WIDTH'(1);
          if (count == LEN_WIDTH'(1)) begin
            state_next = DONE;
          end else if (mode_reg) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end else begin
          state_next = WR;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Port outputs decoded from registered state; op drops to NOP when not granted.
  always_comb begin
    bus.op         = MEM_NOP;
    bus.addr       = (state == WR) ? dst_ptr : src_ptr;
    bus.write_data = mode_reg ? fill_reg : data_reg;
    bus.busy       = (state != IDLE);
    bus.done       = (state == DONE);
    case (state)
      RD:      bus.op = bus.grant ? MEM_READ : MEM_NOP;
      WR:      bus.op = bus.grant ? MEM_WRITE : MEM_NOP;
      default: bus.op = MEM_NOP;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode_reg <= 1'b0;
      desc_reg <= 1'b0;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      data_reg <= '0;
      fill_reg <= '0;
      count    <= '0;
    end else begin
      state    <= state_next;
      mode_reg <= mode_next;
      desc_reg <= desc_next;
      src_ptr  <= src_ptr_next;
      dst_ptr  <= dst_ptr_next;
      data_reg <= data_next;
      fill_reg <= fill_next;
      count    <= count_next;
    end
  end
endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Data-memory initiator (block copy/fill engine) on the memory manager's data port (op/addr/write_data/read_data).
- Copies a block of words from one address range to another, or fills a range with a constant, without core involvement.
- Sits beside the z8 core; the core's memory-port mux selects this block while `grant`=1.

Parameters:
- LEN_WIDTH, WORD_SIZE+1, width of the length field; allows a full-memory length (e.g. 256 at WORD_SIZE=8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src  in  WORD_SIZE  copy source base address; ignored for fill.
- dst  in  WORD_SIZE  destination base address.
- len  in  LEN_WIDTH  number of words.
- fill_value  in  WORD_SIZE  word written in fill mode.
- grant  in  1  1 = port owned by this block this cycle.
- op  out  2  memory op: MEM_READ, MEM_WRITE, or MEM_NOP (2'b00, instruction_set).
- addr  out  WORD_SIZE  memory address.
- write_data  out  WORD_SIZE  memory write data.
- read_data  in  WORD_SIZE  combinational read data from memory, valid in the same cycle as op=MEM_READ.
- busy  out  1  1 in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, async) forces the following, whether or not a transfer is in progress (mid-transfer reset abandons it with no done pulse):
  - state=IDLE;
  - op=MEM_NOP, addr=0, write_data=0;
  - busy=0, done=0;
  - internal count, pointers and data latch = 0.
- States:
  - IDLE: start=1 latches src, dst, len, mode and fill_value.
    - len=0 -> DONE.
    - mode=copy -> RD.
    - mode=fill -> WR.
  - RD (copy only): drive op=MEM_READ, addr=src_ptr; at the edge, latch read_data into data_reg -> WR.
  - WR: drive op=MEM_WRITE, addr=dst_ptr, write_data = data_reg (copy) or fill_value (fill); at the edge, advance pointers and decrement count.
    - count reaches 0 -> DONE.
    - otherwise copy -> RD, fill -> WR.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Direction:
  - Copy is descending when dst > src and dst < src+len (overlap, computed once at start).
  - Descending pointers start at src+len-1 and dst+len-1 and decrement.
  - All other cases ascend.
  - Fill always ascends.
- Arithmetic: pointers wrap modulo 2^WORD_SIZE; the overlap test is done in WORD_SIZE+1 bits, without wrap.
- Stall: in RD or WR with grant=0:
  - op=MEM_NOP;
  - no latch, no pointer or count update, state held;
  - addr and write_data keep their values.
- Outputs are combinational from registered state; op=MEM_NOP in IDLE and DONE.
- Latency, with grant held at 1, measured as cycles from the start edge to the done-high cycle:
  - copy: 2*len+1;
  - fill: len+1;
  - len=0: 1.
- start while busy=1 is ignored.
- start in the DONE cycle is ignored; it is accepted the following cycle in IDLE.
- Exactly one memory access per granted cycle; no write ever precedes its matching read.

Test Plan (WORD_SIZE=8, behavioural memory model):
- Copy: mem[0x10..0x13]=11,22,33,44; start copy src=0x10 dst=0x40 len=4 -> mem[0x40..0x43]=11,22,33,44; done high exactly at cycle 9; 4 reads and 4 writes alternating.
- Fill: start fill dst=0xFE len=4 fill_value=0xA5 -> mem[0xFE],[0xFF],[0x00],[0x01]=0xA5 (address wrap); done at cycle 5.
- Overlapping copy: mem[0x20..0x23]=1,2,3,4; copy src=0x20 dst=0x22 len=4 -> mem[0x22..0x25]=1,2,3,4; first write addr=0x25.
- Stall: grant=0 for 3 cycles mid-copy of len=2 -> op=MEM_NOP during the stall; result correct; done at cycle 5+3=8.
- len=0 and ignored start: start len=0 -> done at cycle 1, no accesses; second start pulse during a busy copy -> no effect, single done pulse.
- Reset mid-transfer: reset=0 during WR of a len=8 copy -> op=MEM_NOP, busy=0 immediately; no done pulse; a new copy after release completes normally.
